// File: rtl/falu16_vec_seq_pkg.sv
// Shared definitions for the FALU16 vector sequencer: opcodes, alu_ctl bit
// positions, FSM states and the opcode-to-control decoder.
package falu16_seq_pkg;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_ITF = 3'd3;
    localparam logic [2:0] OP_FTI = 3'd4;
    localparam logic [2:0] OP_MAX = 3'd5;
    localparam logic [2:0] OP_MIN = 3'd6;
    localparam logic [2:0] OP_MOV = 3'd7;

    localparam int CTL_EN  = 7;
    localparam int CTL_ADD = 6;
    localparam int CTL_SUB = 5;
    localparam int CTL_MUL = 4;
    localparam int CTL_ITF = 3;
    localparam int CTL_FTI = 2;
    localparam int CTL_MAX = 1;
    localparam int CTL_MIN = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_CPL   = 2'd3
    } state_t;

    // MOV leaves the whole word at zero so the lanes pass op1 through.
    function automatic logic [7:0] op_to_ctl(input logic [2:0] op);
        logic [7:0] ctl;
        ctl = '0;
        case (op)
            OP_ADD:  ctl[CTL_ADD] = 1'b1;
            OP_SUB:  ctl[CTL_SUB] = 1'b1;
            OP_MUL:  ctl[CTL_MUL] = 1'b1;
            OP_ITF:  ctl[CTL_ITF] = 1'b1;
            OP_FTI:  ctl[CTL_FTI] = 1'b1;
            OP_MAX:  ctl[CTL_MAX] = 1'b1;
            OP_MIN:  ctl[CTL_MIN] = 1'b1;
            default: ctl = '0;
        endcase
        if (op != OP_MOV) begin
            ctl[CTL_EN] = 1'b1;
        end
        return ctl;
    endfunction

endpackage

// File: rtl/falu16_vec_seq_if.sv
// Instruction issue bus between the VPU issue stage (master) and the
// vector sequencer (slave).
interface falu16_vec_seq_if;
    import falu16_seq_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [4:0]  req_vl;
    logic [4:0]  req_vs1;
    logic [4:0]  req_vs2;
    logic [4:0]  req_vd;
    logic        req_scalar;
    logic [15:0] req_sdata;

    modport master (
        output req_valid,
        output req_op,
        output req_vl,
        output req_vs1,
        output req_vs2,
        output req_vd,
        output req_scalar,
        output req_sdata,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_op,
        input  req_vl,
        input  req_vs1,
        input  req_vs2,
        input  req_vd,
        input  req_scalar,
        input  req_sdata,
        output req_ready
    );

endinterface

// File: rtl/falu16_vec_seq_mask.sv
// Writeback lane mask: every lane enabled except in the final group of a
// vector whose length is not a multiple of the lane count.
module falu16_seq_mask
    import falu16_seq_pkg::*;
#(
    parameter int LANES = 4,
    parameter int LW    = $clog2(LANES)
) (
    input  logic             last,
    input  logic [LW-1:0]    tail,
    output logic [LANES-1:0] mask
);

    always_comb begin
        mask = '1;
        if (last && (tail != '0)) begin
            for (int i = 0; i < LANES; i++) begin
                mask[i] = (i < int'(tail));
            end
        end
    end

endmodule

// File: rtl/falu16_vec_seq.sv
// Vector half-precision sequencer: splits one vector instruction into
// lane-wide groups, reads the VRF, drives the FALU16 lanes, and writes back.
module falu16_vec_seq
    import falu16_seq_pkg::*;
#(
    parameter int LANES    = 4,
    parameter int VLEN_MAX = 16,
    parameter int GRP_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    falu16_vec_seq_if.slave       req,
    output logic                  rd_en,
    output logic [5+GRP_W-1:0]    rd_addr1,
    output logic [5+GRP_W-1:0]    rd_addr2,
    input  logic [16*LANES-1:0]   rd_data1,
    input  logic [16*LANES-1:0]   rd_data2,
    output logic [16*LANES-1:0]   alu_op1,
    output logic [16*LANES-1:0]   alu_op2,
    output logic [7:0]            alu_ctl,
    input  logic [16*LANES-1:0]   alu_res,
    output logic                  wb_valid,
    output logic [5+GRP_W-1:0]    wb_addr,
    output logic [LANES-1:0]      wb_mask,
    output logic [16*LANES-1:0]   wb_data,
    output logic                  busy,
    output logic                  cpl_valid
);

    localparam int LW   = $clog2(LANES);
    localparam int VL_W = 5;

    state_t state;
    state_t state_n;

    logic [2:0]        op_q;
    logic [4:0]        vs1_q;
    logic [4:0]        vs2_q;
    logic [4:0]        vd_q;
    logic              scalar_q;
    logic [15:0]       sdata_q;
    logic [LW-1:0]     tail_q;
    logic [VL_W-1:0]   rem_cnt;
    logic [GRP_W-1:0]  grp;
    logic              drain_cnt;

    logic              s1_valid;
    logic              s1_last;
    logic [GRP_W-1:0]  s1_grp;
    logic [LANES-1:0]  s1_mask;

    logic [VL_W-1:0]   vl_eff;
    logic              accept;
    logic              issue_last;

    assign vl_eff     = (req.req_vl > VL_W'(VLEN_MAX)) ? VL_W'(VLEN_MAX) : req.req_vl;
    assign accept     = req.req_valid && (state == ST_IDLE);
    assign issue_last = (rem_cnt <= VL_W'(LANES));
    assign req.req_ready = (state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        rd_en     = 1'b0;
        cpl_valid = 1'b0;
        busy      = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_n = (vl_eff == '0) ? ST_CPL : ST_RUN;
                end
            end
            ST_RUN: begin
                rd_en = 1'b1;
                if (issue_last) begin
                    state_n = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt) begin
                    state_n = ST_CPL;
                end
            end
            ST_CPL: begin
                cpl_valid = 1'b1;
                state_n   = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    assign rd_addr1 = rd_en ? {vs1_q, grp} : '0;
    assign rd_addr2 = rd_en ? {vs2_q, grp} : '0;

    // rem_cnt counts elements still to issue; the group that exhausts it is the tail.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            vs1_q     <= '0;
            vs2_q     <= '0;
            vd_q      <= '0;
            scalar_q  <= 1'b0;
            sdata_q   <= '0;
            tail_q    <= '0;
            rem_cnt   <= '0;
            grp       <= '0;
            drain_cnt <= 1'b0;
        end else begin
            if (accept) begin
                op_q     <= req.req_op;
                vs1_q    <= req.req_vs1;
                vs2_q    <= req.req_vs2;
                vd_q     <= req.req_vd;
                scalar_q <= req.req_scalar;
                sdata_q  <= req.req_sdata;
                tail_q   <= vl_eff[LW-1:0];
                rem_cnt  <= vl_eff;
                grp      <= '0;
            end else if (state == ST_RUN) begin
                grp     <= grp + GRP_W'(1);
                rem_cnt <= rem_cnt - VL_W'(LANES);
            end
            drain_cnt <= (state == ST_DRAIN) ? ~drain_cnt : 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_grp   <= '0;
        end else begin
            s1_valid <= rd_en;
            if (rd_en) begin
                s1_last <= issue_last;
                s1_grp  <= grp;
            end
        end
    end

    // Lane operands are only presented while a group sits in stage 1.
    always_comb begin
        alu_op1 = '0;
        alu_op2 = '0;
        alu_ctl = '0;
        if (s1_valid) begin
            alu_op1 = rd_data1;
            alu_op2 = scalar_q ? {LANES{sdata_q}} : rd_data2;
            alu_ctl = op_to_ctl(op_q);
        end
    end

    falu16_seq_mask #(
        .LANES (LANES),
        .LW    (LW)
    ) u_mask (
        .last (s1_last),
        .tail (tail_q),
        .mask (s1_mask)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid <= 1'b0;
            wb_addr  <= '0;
            wb_mask  <= '0;
            wb_data  <= '0;
        end else begin
            wb_valid <= s1_valid;
            if (s1_valid) begin
                wb_addr <= {vd_q, s1_grp};
                wb_mask <= s1_mask;
                wb_data <= alu_res;
            end
        end
    end

endmodule

// File: tb/tb_falu16_vec_seq.sv
// Scoreboard bench for falu16_vec_seq with a static VRF model and an
// integer-add stub standing in for the FALU16 lanes.
module tb_falu16_vec_seq;

    localparam int LANES = 4;
    localparam int GRP_W = 2;
    localparam int AW    = 5 + GRP_W;
    localparam int DW    = 16 * LANES;

    typedef struct {
        int           cyc;
        logic [AW-1:0] a1;
        logic [AW-1:0] a2;
    } rd_exp_t;

    typedef struct {
        int            cyc;
        logic [7:0]    ctl;
        logic [DW-1:0] op1;
        logic [DW-1:0] op2;
    } s1_exp_t;

    typedef struct {
        int             cyc;
        logic [AW-1:0]  addr;
        logic [LANES-1:0] mask;
        logic [DW-1:0]  data;
    } wb_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    falu16_vec_seq_if req_bus();

    logic             rd_en;
    logic [AW-1:0]    rd_addr1;
    logic [AW-1:0]    rd_addr2;
    logic [DW-1:0]    rd_data1 = '0;
    logic [DW-1:0]    rd_data2 = '0;
    logic [DW-1:0]    alu_op1;
    logic [DW-1:0]    alu_op2;
    logic [7:0]       alu_ctl;
    logic [DW-1:0]    alu_res;
    logic             wb_valid;
    logic [AW-1:0]    wb_addr;
    logic [LANES-1:0] wb_mask;
    logic [DW-1:0]    wb_data;
    logic             busy;
    logic             cpl_valid;

    falu16_vec_seq #(
        .LANES    (LANES),
        .VLEN_MAX (16),
        .GRP_W    (GRP_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req_bus),
        .rd_en     (rd_en),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .rd_data1  (rd_data1),
        .rd_data2  (rd_data2),
        .alu_op1   (alu_op1),
        .alu_op2   (alu_op2),
        .alu_ctl   (alu_ctl),
        .alu_res   (alu_res),
        .wb_valid  (wb_valid),
        .wb_addr   (wb_addr),
        .wb_mask   (wb_mask),
        .wb_data   (wb_data),
        .busy      (busy),
        .cpl_valid (cpl_valid)
    );

    logic [DW-1:0] vrf [128];
    int cyc = 0;
    int checks = 0;
    int errors = 0;

    rd_exp_t rd_q[$];
    s1_exp_t s1_q[$];
    wb_exp_t wb_q[$];
    int      cpl_q[$];

    always_comb begin
        alu_res = '0;
        for (int i = 0; i < LANES; i++) begin
            alu_res[16*i +: 16] = alu_op1[16*i +: 16] + alu_op2[16*i +: 16];
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rd_en) begin
            rd_data1 <= vrf[rd_addr1];
            rd_data2 <= vrf[rd_addr2];
        end
    end

    function automatic logic [7:0] ctl_model(input logic [2:0] op);
        case (op)
            3'd0:    return 8'hC0;
            3'd1:    return 8'hA0;
            3'd2:    return 8'h90;
            3'd3:    return 8'h88;
            3'd4:    return 8'h84;
            3'd5:    return 8'h82;
            3'd6:    return 8'h81;
            default: return 8'h00;
        endcase
    endfunction

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic apply_stimulus(input logic [2:0] op, input logic [4:0] vl,
                                  input logic [4:0] vs1, input logic [4:0] vs2,
                                  input logic [4:0] vd, input logic scalar,
                                  input logic [15:0] sdata, input bit keep_valid,
                                  output int t_acc);
        int n;
        int vle;
        int grps;
        int tl;
        rd_exp_t re;
        s1_exp_t se;
        wb_exp_t we;
        @(negedge clk);
        req_bus.req_op     = op;
        req_bus.req_vl     = vl;
        req_bus.req_vs1    = vs1;
        req_bus.req_vs2    = vs2;
        req_bus.req_vd     = vd;
        req_bus.req_scalar = scalar;
        req_bus.req_sdata  = sdata;
        req_bus.req_valid  = 1'b1;
        n = 0;
        while (!req_bus.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        t_acc = cyc;
        if (!req_bus.req_ready) begin
            check_output("accept_timeout", 64'(req_bus.req_ready), 64'd1);
            req_bus.req_valid = 1'b0;
            return;
        end
        vle  = (int'(vl) > 16) ? 16 : int'(vl);
        grps = (vle + LANES - 1) / LANES;
        tl   = vle % LANES;
        if (grps == 0) begin
            cpl_q.push_back(t_acc + 1);
        end else begin
            for (int g = 0; g < grps; g++) begin
                re.cyc = t_acc + 1 + g;
                re.a1  = {vs1, 2'(g)};
                re.a2  = {vs2, 2'(g)};
                rd_q.push_back(re);
                se.cyc = t_acc + 2 + g;
                se.ctl = ctl_model(op);
                se.op1 = vrf[re.a1];
                se.op2 = scalar ? {LANES{sdata}} : vrf[re.a2];
                s1_q.push_back(se);
                we.cyc  = t_acc + 3 + g;
                we.addr = {vd, 2'(g)};
                we.mask = ((g == grps - 1) && (tl != 0)) ? 4'((1 << tl) - 1) : 4'hF;
                for (int i = 0; i < LANES; i++) begin
                    we.data[16*i +: 16] = se.op1[16*i +: 16] + se.op2[16*i +: 16];
                end
                wb_q.push_back(we);
            end
            cpl_q.push_back(t_acc + grps + 3);
        end
        @(posedge clk);
        if (!keep_valid) begin
            #1 req_bus.req_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_output("idle_reached", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    // Monitor: pops expectations as the DUT presents reads, stage-1 operands,
    // writebacks and completions.
    initial begin
        rd_exp_t re;
        s1_exp_t se;
        wb_exp_t we;
        int      ce;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (rd_en) begin
                    if (rd_q.size() == 0) begin
                        check_output("rd_en_unexpected", 64'(rd_en), 64'd0);
                    end else begin
                        re = rd_q.pop_front();
                        check_output("rd_cycle", 64'(cyc), 64'(re.cyc));
                        check_output("rd_addr1", 64'(rd_addr1), 64'(re.a1));
                        check_output("rd_addr2", 64'(rd_addr2), 64'(re.a2));
                    end
                end else if (rd_q.size() > 0 && rd_q[0].cyc <= cyc) begin
                    check_output("rd_en_missing", 64'(rd_en), 64'd1);
                    void'(rd_q.pop_front());
                end

                if (s1_q.size() > 0 && s1_q[0].cyc == cyc) begin
                    se = s1_q.pop_front();
                    check_output("alu_ctl", 64'(alu_ctl), 64'(se.ctl));
                    check_output("alu_op1", alu_op1, se.op1);
                    check_output("alu_op2", alu_op2, se.op2);
                end else begin
                    check_output("alu_ctl_idle", 64'(alu_ctl), 64'd0);
                    if (s1_q.size() > 0 && s1_q[0].cyc < cyc) begin
                        void'(s1_q.pop_front());
                    end
                end

                if (wb_valid) begin
                    if (wb_q.size() == 0) begin
                        check_output("wb_valid_unexpected", 64'(wb_valid), 64'd0);
                    end else begin
                        we = wb_q.pop_front();
                        check_output("wb_cycle", 64'(cyc), 64'(we.cyc));
                        check_output("wb_addr", 64'(wb_addr), 64'(we.addr));
                        check_output("wb_mask", 64'(wb_mask), 64'(we.mask));
                        check_output("wb_data", wb_data, we.data);
                    end
                end else if (wb_q.size() > 0 && wb_q[0].cyc <= cyc) begin
                    check_output("wb_valid_missing", 64'(wb_valid), 64'd1);
                    void'(wb_q.pop_front());
                end

                if (cpl_valid) begin
                    if (cpl_q.size() == 0) begin
                        check_output("cpl_valid_unexpected", 64'(cpl_valid), 64'd0);
                    end else begin
                        ce = cpl_q.pop_front();
                        check_output("cpl_cycle", 64'(cyc), 64'(ce));
                    end
                end else if (cpl_q.size() > 0 && cpl_q[0] <= cyc) begin
                    check_output("cpl_valid_missing", 64'(cpl_valid), 64'd1);
                    void'(cpl_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t1;
        int t2;
        int ops[5];
        ops = '{1, 3, 4, 5, 6};

        for (int r = 0; r < 128; r++) begin
            for (int i = 0; i < LANES; i++) begin
                if ((r >> 2) == 1) begin
                    vrf[r][16*i +: 16] = 16'h0001;
                end else if ((r >> 2) == 2) begin
                    vrf[r][16*i +: 16] = 16'h0010;
                end else begin
                    vrf[r][16*i +: 16] = 16'(r * 16 + i + 16'h0100);
                end
            end
        end

        req_bus.req_valid  = 1'b0;
        req_bus.req_op     = '0;
        req_bus.req_vl     = '0;
        req_bus.req_vs1    = '0;
        req_bus.req_vs2    = '0;
        req_bus.req_vd     = '0;
        req_bus.req_scalar = 1'b0;
        req_bus.req_sdata  = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_output("reset_req_ready", 64'(req_bus.req_ready), 64'd1);
        check_output("reset_busy", 64'(busy), 64'd0);
        check_output("reset_rd_en", 64'(rd_en), 64'd0);
        check_output("reset_wb_valid", 64'(wb_valid), 64'd0);
        check_output("reset_cpl_valid", 64'(cpl_valid), 64'd0);
        check_output("reset_wb_data", wb_data, 64'd0);

        $display("[TB] basic add, vl=8");
        apply_stimulus(3'd0, 5'd8, 5'd1, 5'd2, 5'd3, 1'b0, 16'h0000, 1'b0, t1);
        wait_idle();

        $display("[TB] tail mask, MUL vl=6");
        apply_stimulus(3'd2, 5'd6, 5'd5, 5'd6, 5'd7, 1'b0, 16'h0000, 1'b0, t1);
        wait_idle();

        $display("[TB] scalar broadcast and MOV");
        apply_stimulus(3'd0, 5'd4, 5'd1, 5'd2, 5'd4, 1'b1, 16'h3C00, 1'b0, t1);
        wait_idle();
        apply_stimulus(3'd7, 5'd4, 5'd9, 5'd10, 5'd11, 1'b0, 16'h0000, 1'b0, t1);
        wait_idle();

        $display("[TB] remaining opcodes with assorted lengths");
        for (int k = 0; k < 5; k++) begin
            apply_stimulus(3'(ops[k]), 5'(ops[k] + 1), 5'(12 + k), 5'(20 + k), 5'(26 + k),
                           1'b0, 16'h0000, 1'b0, t1);
            wait_idle();
        end

        $display("[TB] zero length");
        apply_stimulus(3'd0, 5'd0, 5'd1, 5'd2, 5'd3, 1'b0, 16'h0000, 1'b0, t1);
        @(negedge clk);
        check_output("vl0_ready_t1", 64'(req_bus.req_ready), 64'd0);
        @(negedge clk);
        check_output("vl0_ready_t2", 64'(req_bus.req_ready), 64'd1);
        wait_idle();

        $display("[TB] length clamp and back-to-back accept");
        apply_stimulus(3'd0, 5'd20, 5'd8, 5'd9, 5'd10, 1'b0, 16'h0000, 1'b1, t1);
        apply_stimulus(3'd1, 5'd5, 5'd8, 5'd12, 5'd8, 1'b0, 16'h0000, 1'b0, t2);
        check_output("b2b_accept_cycle", 64'(t2), 64'(t1 + 4 + 4));
        wait_idle();

        $display("[TB] reset mid-operation");
        apply_stimulus(3'd0, 5'd16, 5'd1, 5'd2, 5'd13, 1'b0, 16'h0000, 1'b0, t1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rd_q.delete();
        s1_q.delete();
        wb_q.delete();
        cpl_q.delete();
        @(negedge clk);
        check_output("rst_rd_en", 64'(rd_en), 64'd0);
        check_output("rst_wb_valid", 64'(wb_valid), 64'd0);
        check_output("rst_cpl_valid", 64'(cpl_valid), 64'd0);
        check_output("rst_alu_ctl", 64'(alu_ctl), 64'd0);
        check_output("rst_alu_op1", alu_op1, 64'd0);
        check_output("rst_alu_op2", alu_op2, 64'd0);
        check_output("rst_wb_mask", 64'(wb_mask), 64'd0);
        check_output("rst_wb_data", wb_data, 64'd0);
        check_output("rst_busy", 64'(busy), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check_output("rst_release_ready", 64'(req_bus.req_ready), 64'd1);
        repeat (8) @(negedge clk);

        $display("[TB] recovery after reset");
        apply_stimulus(3'd5, 5'd7, 5'd3, 5'd4, 5'd5, 1'b0, 16'h0000, 1'b0, t1);
        wait_idle();

        check_output("rd_queue_drained", 64'(rd_q.size()), 64'd0);
        check_output("s1_queue_drained", 64'(s1_q.size()), 64'd0);
        check_output("wb_queue_drained", 64'(wb_q.size()), 64'd0);
        check_output("cpl_queue_drained", 64'(cpl_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
